// File: rtl/fp_mul_pkg.sv
// Shared types and constant builders for the widening sequential FP multiplier.
package fp_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_e;

   // Wide enough for any practical output format; callers slice the low bits.
   localparam int PAT_W = 128;

   function automatic int bias(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // +inf with sign 0: exponent all ones, fraction zero.
   function automatic logic [PAT_W-1:0] inf_pat(input int oexp_w, input int oman_w);
      logic [PAT_W-1:0] p;
      p = '0;
      for (int i = 0; i < oexp_w; i++) p[oman_w + i] = 1'b1;
      return p;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
   function automatic logic [PAT_W-1:0] qnan_pat(input int oexp_w, input int oman_w);
      logic [PAT_W-1:0] p;
      p = inf_pat(oexp_w, oman_w);
      p[oman_w - 1] = 1'b1;
      return p;
   endfunction

endpackage

// File: rtl/fp_mul_widening_seq_core.sv
// Iterative radix-2 shift-add unsigned W x W multiplier. start_i loads the
// operands; done_o is high during the cycle whose closing edge writes the last
// partial product, so prod_o is final from the next cycle on.
module shift_add_mul_core #(
   parameter int W = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [W-1:0]   mcand_i,
   input  logic [W-1:0]   mplr_i,
   output logic           done_o,
   output logic [2*W-1:0] prod_o
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]   mcand_q;
   logic [W-1:0]   mplr_q;
   logic [2*W-1:0] acc_q;
   logic [CW-1:0]  cnt_q;
   logic           run_q;
   logic [W:0]     sum_d;
   logic           last_d;

   // Add the multiplicand into the upper half when the multiplier LSB is set.
   always_comb begin
      sum_d  = {1'b0, acc_q[2*W-1:W]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
      last_d = run_q && (cnt_q == CW'(W - 1));
   end

   // Load on start, then shift accumulator and multiplier right for W cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q <= mcand_i;
         mplr_q  <= mplr_i;
         acc_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b1;
      end else if (run_q) begin
         acc_q  <= {sum_d, acc_q[W-1:1]};
         mplr_q <= mplr_q >> 1;
         cnt_q  <= cnt_q + 1'b1;
         if (last_d) run_q <= 1'b0;
      end
   end

   assign done_o = last_d;
   assign prod_o = acc_q;

endmodule

// File: rtl/fp_mul_widening_seq.sv
// Widening IEEE-754 multiplier: exact product of two EXP_W/MAN_W operands in
// OEXP_W/OMAN_W format, one operation in flight behind valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | shift-add core iterating over MAN_W+1 multiplier bits
// NORM  | normalise product, build exponent, load result
// DONE  | result valid and held until out_ready
module fp_mul_widening_seq
   import fp_mul_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23,
   parameter int OEXP_W = 11,
   parameter int OMAN_W = 52
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       a,
   input  logic [EXP_W+MAN_W:0]       b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OEXP_W+OMAN_W:0]     result,
   output logic                       busy
);
   localparam int IW = 1 + EXP_W + MAN_W;
   localparam int RW = 1 + OEXP_W + OMAN_W;
   localparam int MW = MAN_W + 1;
   localparam int PW = 2 * MW;
   localparam int FW = 2 * MAN_W + 1;

   // Exponent rebias is always positive since OEXP_W >= EXP_W+2.
   localparam logic [OEXP_W:0] EADJ = (OEXP_W+1)'(bias(OEXP_W) - 2 * bias(EXP_W));
   localparam logic [PAT_W-1:0] QNAN_FULL = qnan_pat(OEXP_W, OMAN_W);
   localparam logic [PAT_W-1:0] INF_FULL  = inf_pat(OEXP_W, OMAN_W);
   localparam logic [RW-1:0]    QNAN_RES  = QNAN_FULL[RW-1:0];
   localparam logic [RW-1:0]    INF_RES   = INF_FULL[RW-1:0];

   state_e          state_q;
   logic            sign_q;
   logic [OEXP_W:0] esum_q;
   logic [RW-1:0]   result_q;
   logic            out_valid_q;
   logic            in_ready_q;
   logic            busy_q;

   logic [EXP_W-1:0]  ea, eb;
   logic [MAN_W-1:0]  fa, fb;
   logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic              sign_d, special_d, accept;
   logic [OEXP_W:0]   esum_d, eo_d;
   logic [RW-1:0]     spec_res_d, norm_res_d;
   logic [FW-1:0]     frac_d;
   logic [OMAN_W-1:0] ofrac_d;
   logic              norm_n;
   logic              core_done;
   logic [PW-1:0]     prod;

   // Operand classification and special-result selection at the accept edge.
   always_comb begin
      ea     = a[IW-2:MAN_W];
      eb     = b[IW-2:MAN_W];
      fa     = a[MAN_W-1:0];
      fb     = b[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (&ea) && (fa == '0);
      b_inf  = (&eb) && (fb == '0);
      a_nan  = (&ea) && (fa != '0);
      b_nan  = (&eb) && (fb != '0);
      sign_d = a[IW-1] ^ b[IW-1];
      esum_d = (OEXP_W+1)'(ea) + (OEXP_W+1)'(eb);
      accept = in_valid && in_ready_q;
      special_d = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         spec_res_d = QNAN_RES;
      else if (a_inf || b_inf)
         spec_res_d = INF_RES | {sign_d, {(RW-1){1'b0}}};
      else
         spec_res_d = {sign_d, {(RW-1){1'b0}}};
   end

   // Product in [1,4): drop the hidden one, bump exponent when the top bit is set.
   always_comb begin
      norm_n  = prod[PW-1];
      frac_d  = norm_n ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      ofrac_d = '0;
      ofrac_d[OMAN_W-1 -: FW] = frac_d;
      eo_d    = esum_q + EADJ + {{OEXP_W{1'b0}}, norm_n};
      norm_res_d = {sign_q, eo_d[OEXP_W-1:0], ofrac_d};
   end

   shift_add_mul_core #(.W(MW)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept && !special_d),
      .mcand_i ({1'b1, fa}),
      .mplr_i  ({1'b1, fb}),
      .done_o  (core_done),
      .prod_o  (prod)
   );

   // Handshake FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         esum_q      <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               sign_q     <= sign_d;
               esum_q     <= esum_d;
               in_ready_q <= 1'b0;
               if (special_d) begin
                  result_q    <= spec_res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  busy_q  <= 1'b1;
                  state_q <= MUL;
               end
            end
            MUL: if (core_done) state_q <= NORM;
            NORM: begin
               result_q    <= norm_res_d;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result    = result_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign busy      = busy_q;

endmodule
